// File: rtl/branch_resolve_queue_pkg.sv
// -----------------------------------------------------------------------------
// branch_resolve_queue_pkg
// Shared definitions for the branch resolve queue:
//   - default geometry (queue depth, BTB tag/index widths, index LSB in the PC)
//   - branch-info field ranges of the packed {dir, type, target} bundle
//   - branch type and 2-bit direction counter encodings
//   - queue entry layout {pc, hit, dir, tar, type} (68 bits)
//   - pack_binfo helper building the branch-info bundle
// -----------------------------------------------------------------------------
package branch_resolve_queue_pkg;

    // Default geometry: tag = pc[31:10], index = pc[9:2]
    localparam int BRQ_DEPTH   = 8;
    localparam int BRQ_TAG_W   = 22;
    localparam int BRQ_IDX_W   = 8;
    localparam int BRQ_IDX_LSB = 2;

    // Branch-info bundle field ranges
    localparam int BI_TAR_LSB = 0;
    localparam int BI_TAR_MSB = 31;
    localparam int BI_TYP_LSB = 32;
    localparam int BI_TYP_MSB = 33;
    localparam int BI_DIR     = 34;
    localparam int BI_W       = 35;

    // Branch type encodings; BT_NONE is what a non-branch writes to the BTB
    typedef enum logic [1:0] {
        BT_NONE = 2'd0,
        BT_COND = 2'd1,
        BT_JUMP = 2'd2,
        BT_RET  = 2'd3
    } br_type_e;

    // 2-bit saturating direction counter states used by the BTB
    typedef enum logic [1:0] {
        CNT_SNT = 2'b00,
        CNT_WNT = 2'b01,
        CNT_WT  = 2'b10,
        CNT_ST  = 2'b11
    } ctr_state_e;

    // One tracked prediction
    typedef struct packed {
        logic [31:0] pc;
        logic        hit;
        logic        dir;
        logic [31:0] tar;
        logic [1:0]  typ;
    } brq_entry_t;

    localparam int BRQ_ENTRY_W = $bits(brq_entry_t);

    // Assemble the {dir, type, target} branch-info bundle
    function automatic logic [BI_W-1:0] pack_binfo(
        input logic [31:0] tar,
        input logic [1:0]  typ,
        input logic        dir
    );
        logic [BI_W-1:0] v;
        v = '0;
        v[BI_TAR_MSB:BI_TAR_LSB] = tar;
        v[BI_TYP_MSB:BI_TYP_LSB] = typ;
        v[BI_DIR]                = dir;
        return v;
    endfunction

endpackage

// File: rtl/branch_resolve_queue_fifo.sv
// -----------------------------------------------------------------------------
// brq_fifo
// Generic synchronous FIFO with push, pop and clear.
// Ports:
//   clk, resetn   clock, synchronous active-low reset
//   i_push        write i_din (ignored while full or while clearing)
//   i_pop         discard the head entry (ignored while empty)
//   i_clear       empty the queue; an accompanying pop still retires the head
//   i_din         entry to write
//   o_dout        head entry (combinational read of the head slot)
//   o_count       occupancy 0..DEPTH
//   o_full        count == DEPTH
//   o_empty       count == 0
// -----------------------------------------------------------------------------
module brq_fifo #(
    parameter int WIDTH = 68,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_clear,
    input  logic [WIDTH-1:0]           i_din,
    output logic [WIDTH-1:0]           o_dout,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = {{(AW - 1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_wr;
    logic             w_rd;
    logic [AW-1:0]    w_rd_next;

    assign o_full    = (r_count == DEPTH_C);
    assign o_empty   = (r_count == {(AW + 1){1'b0}});
    assign o_count   = r_count;
    assign o_dout    = r_mem[r_rd_ptr];

    // A push coinciding with a clear is dropped: the clear empties the queue
    assign w_wr      = i_push & ~o_full & ~i_clear;
    assign w_rd      = i_pop & ~o_empty;
    assign w_rd_next = w_rd ? (r_rd_ptr + PTR_ONE) : r_rd_ptr;

    // Storage write port
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointer and occupancy tracking
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            // Collapse the queue onto the slot after the retired head
            r_rd_ptr <= w_rd_next;
            r_wr_ptr <= w_rd_next;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            r_rd_ptr <= w_rd_next;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + {{AW{1'b0}}, 1'b1};
                2'b01:   r_count <= r_count - {{AW{1'b0}}, 1'b1};
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/branch_resolve_queue.sv
// -----------------------------------------------------------------------------
// branch_resolve_queue
// Holds every IF-stage BTB prediction in order until ID resolves it, compares
// prediction with outcome, and emits a registered BTB update bundle plus a
// one-cycle flush/redirect on a mispredict (which also drops all younger
// queued predictions).
// Ports:
//   clk, resetn                  clock, synchronous active-low reset
//   pred_valid/pred_ready        IF prediction handshake (ready = not full)
//   pred_pc/hit/dir/tar/type     prediction record
//   res_valid/res_ready          ID resolve handshake (ready = not empty)
//   res_pc/is_branch/dir/tar/type actual outcome of the oldest instruction
//   upd_*                        BTB update bundle, one cycle after the pop
//   flush/redirect_pc            mispredict pulse and refetch PC
//   err_order                    sticky: resolved PC did not match queue head
//   stat_resolved/stat_mispred   saturating event counters
// -----------------------------------------------------------------------------
module branch_resolve_queue
    import branch_resolve_queue_pkg::*;
#(
    parameter int DEPTH = BRQ_DEPTH,
    parameter int TAG_W = BRQ_TAG_W,
    parameter int IDX_W = BRQ_IDX_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              pred_valid,
    output logic              pred_ready,
    input  logic [31:0]       pred_pc,
    input  logic              pred_hit,
    input  logic              pred_dir,
    input  logic [31:0]       pred_tar,
    input  logic [1:0]        pred_type,
    input  logic              res_valid,
    output logic              res_ready,
    input  logic [31:0]       res_pc,
    input  logic              res_is_branch,
    input  logic              res_dir,
    input  logic [31:0]       res_tar,
    input  logic [1:0]        res_type,
    output logic              upd_valid,
    output logic              upd_pred_flag,
    output logic [TAG_W-1:0]  upd_tag,
    output logic [IDX_W-1:0]  upd_index,
    output logic [31:0]       upd_tar,
    output logic [1:0]        upd_type,
    output logic              upd_dir,
    output logic              flush,
    output logic [31:0]       redirect_pc,
    output logic              err_order,
    output logic [31:0]       stat_resolved,
    output logic [31:0]       stat_mispred
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [31:0] SAT_MAX = 32'hFFFF_FFFF;

    brq_entry_t             w_din;
    brq_entry_t             w_head;
    logic [BRQ_ENTRY_W-1:0] w_head_raw;
    logic [CW-1:0]          w_count;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_clear;

    logic                   w_order_bad;
    logic                   w_hit;
    logic                   w_p_taken;
    logic                   w_a_taken;
    logic                   w_mis;
    logic                   w_upd_valid;
    logic                   w_need_write;
    logic [31:0]            w_upd_tar;
    logic [1:0]             w_upd_type;
    logic [BI_W-1:0]        w_binfo;
    logic [31:0]            w_redirect;

    logic                   r_upd_valid;
    logic                   r_upd_pred_flag;
    logic [TAG_W-1:0]       r_upd_tag;
    logic [IDX_W-1:0]       r_upd_index;
    logic [BI_W-1:0]        r_upd_binfo;
    logic                   r_flush;
    logic [31:0]            r_redirect_pc;
    logic                   r_err_order;
    logic [31:0]            r_stat_resolved;
    logic [31:0]            r_stat_mispred;

    // Handshakes: readiness depends only on registered occupancy
    assign pred_ready = ~w_full;
    assign res_ready  = (w_count != '0);
    assign w_push     = pred_valid & pred_ready;
    assign w_pop      = res_valid & ~w_empty;
    assign w_clear    = w_pop & w_mis;

    assign w_din.pc   = pred_pc;
    assign w_din.hit  = pred_hit;
    assign w_din.dir  = pred_dir;
    assign w_din.tar  = pred_tar;
    assign w_din.typ  = pred_type;
    assign w_head     = brq_entry_t'(w_head_raw);

    brq_fifo #(
        .WIDTH (BRQ_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (w_clear),
        .i_din   (w_din),
        .o_dout  (w_head_raw),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Prediction vs. outcome. An out-of-order resolve cannot trust the head's
    // BTB hit, so it is treated as a miss.
    assign w_order_bad  = (res_pc != w_head.pc);
    assign w_hit        = w_head.hit & ~w_order_bad;
    assign w_p_taken    = w_hit & w_head.dir;
    assign w_a_taken    = res_is_branch & res_dir;
    assign w_mis        = (w_p_taken != w_a_taken) |
                          (w_a_taken & (w_head.tar != res_tar));

    // BTB write needed when a branch's entry is missing/stale, or when a
    // non-branch falsely hit and its entry must be invalidated.
    assign w_upd_valid  = res_is_branch | w_hit;
    assign w_need_write = res_is_branch ?
                          (~w_hit | (w_head.tar != res_tar) | (w_head.typ != res_type)) :
                          w_hit;
    assign w_upd_tar    = res_is_branch ? res_tar : 32'd0;
    assign w_upd_type   = res_is_branch ? res_type : 2'(BT_NONE);
    assign w_binfo      = pack_binfo(w_upd_tar, w_upd_type, w_a_taken);
    // Not-taken refetch skips the delay slot
    assign w_redirect   = w_a_taken ? res_tar : (res_pc + 32'd8);

    // Update bundle and flush pulse, live only in the cycle after a pop
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_upd_valid     <= 1'b0;
            r_upd_pred_flag <= 1'b0;
            r_upd_tag       <= '0;
            r_upd_index     <= '0;
            r_upd_binfo     <= '0;
            r_flush         <= 1'b0;
            r_redirect_pc   <= 32'd0;
        end else if (w_pop) begin
            r_upd_valid     <= w_upd_valid;
            r_upd_pred_flag <= ~w_need_write;
            r_upd_tag       <= res_pc[31 -: TAG_W];
            r_upd_index     <= res_pc[BRQ_IDX_LSB +: IDX_W];
            r_upd_binfo     <= w_binfo;
            r_flush         <= w_mis;
            r_redirect_pc   <= w_mis ? w_redirect : 32'd0;
        end else begin
            r_upd_valid     <= 1'b0;
            r_upd_pred_flag <= 1'b0;
            r_upd_tag       <= '0;
            r_upd_index     <= '0;
            r_upd_binfo     <= '0;
            r_flush         <= 1'b0;
            r_redirect_pc   <= 32'd0;
        end
    end

    // Sticky order-error flag
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_err_order <= 1'b0;
        end else if (w_pop && w_order_bad) begin
            r_err_order <= 1'b1;
        end else begin
            r_err_order <= r_err_order;
        end
    end

    // Saturating resolve / mispredict counters
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_stat_resolved <= 32'd0;
            r_stat_mispred  <= 32'd0;
        end else begin
            if (w_pop && (r_stat_resolved != SAT_MAX)) begin
                r_stat_resolved <= r_stat_resolved + 32'd1;
            end
            if (w_pop && w_mis && (r_stat_mispred != SAT_MAX)) begin
                r_stat_mispred <= r_stat_mispred + 32'd1;
            end
        end
    end

    assign upd_valid     = r_upd_valid;
    assign upd_pred_flag = r_upd_pred_flag;
    assign upd_tag       = r_upd_tag;
    assign upd_index     = r_upd_index;
    assign upd_tar       = r_upd_binfo[BI_TAR_MSB:BI_TAR_LSB];
    assign upd_type      = r_upd_binfo[BI_TYP_MSB:BI_TYP_LSB];
    assign upd_dir       = r_upd_binfo[BI_DIR];
    assign flush         = r_flush;
    assign redirect_pc   = r_redirect_pc;
    assign err_order     = r_err_order;
    assign stat_resolved = r_stat_resolved;
    assign stat_mispred  = r_stat_mispred;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve_queue
// Directed scenarios plus randomized traffic against a queue-based reference
// model of the branch resolve queue.
// -----------------------------------------------------------------------------
module tb_branch_resolve_queue;

    logic        clk;
    logic        resetn;
    logic        pred_valid;
    logic        pred_ready;
    logic [31:0] pred_pc;
    logic        pred_hit;
    logic        pred_dir;
    logic [31:0] pred_tar;
    logic [1:0]  pred_type;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_pc;
    logic        res_is_branch;
    logic        res_dir;
    logic [31:0] res_tar;
    logic [1:0]  res_type;
    logic        upd_valid;
    logic        upd_pred_flag;
    logic [21:0] upd_tag;
    logic [7:0]  upd_index;
    logic [31:0] upd_tar;
    logic [1:0]  upd_type;
    logic        upd_dir;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        err_order;
    logic [31:0] stat_resolved;
    logic [31:0] stat_mispred;

    int checks;
    int errors;

    branch_resolve_queue dut (
        .clk(clk), .resetn(resetn),
        .pred_valid(pred_valid), .pred_ready(pred_ready), .pred_pc(pred_pc),
        .pred_hit(pred_hit), .pred_dir(pred_dir), .pred_tar(pred_tar), .pred_type(pred_type),
        .res_valid(res_valid), .res_ready(res_ready), .res_pc(res_pc),
        .res_is_branch(res_is_branch), .res_dir(res_dir), .res_tar(res_tar), .res_type(res_type),
        .upd_valid(upd_valid), .upd_pred_flag(upd_pred_flag), .upd_tag(upd_tag),
        .upd_index(upd_index), .upd_tar(upd_tar), .upd_type(upd_type), .upd_dir(upd_dir),
        .flush(flush), .redirect_pc(redirect_pc), .err_order(err_order),
        .stat_resolved(stat_resolved), .stat_mispred(stat_mispred)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic        hit;
        logic        dir;
        logic [31:0] tar;
        logic [1:0]  typ;
    } ent_t;

    ent_t        mq[$];
    logic        e_upd_valid, e_flag, e_dir, e_flush, e_err;
    logic [21:0] e_tag;
    logic [7:0]  e_index;
    logic [31:0] e_tar, e_redirect, e_res_cnt, e_mis_cnt;
    logic [1:0]  e_type;

    // Predict the effect of the coming clock edge from the current inputs
    task automatic model_edge();
        ent_t h;
        ent_t n;
        bit   can_push, do_push, do_pop, hit_ok, pt, at, mis;
        can_push    = (mq.size() != 8);
        do_push     = pred_valid && can_push;
        do_pop      = res_valid && (mq.size() != 0);
        e_upd_valid = 1'b0; e_flag = 1'b0; e_dir = 1'b0; e_flush = 1'b0;
        e_tag = 22'd0; e_index = 8'd0; e_tar = 32'd0; e_type = 2'd0; e_redirect = 32'd0;
        if (!resetn) begin
            mq.delete();
            e_err = 1'b0; e_res_cnt = 32'd0; e_mis_cnt = 32'd0;
        end else begin
            mis = 1'b0;
            if (do_pop) begin
                h = mq.pop_front();
                if (res_pc != h.pc) e_err = 1'b1;
                hit_ok = h.hit && (res_pc == h.pc);
                pt  = hit_ok && h.dir;
                at  = res_is_branch && res_dir;
                mis = (pt != at) || (at && (h.tar != res_tar));
                e_upd_valid = res_is_branch || hit_ok;
                if (res_is_branch)
                    e_flag = !(!hit_ok || h.tar != res_tar || h.typ != res_type);
                else
                    e_flag = !hit_ok;
                e_tag   = 22'(res_pc / 1024);
                e_index = 8'((res_pc / 4) % 256);
                e_tar   = res_is_branch ? res_tar : 32'd0;
                e_type  = res_is_branch ? res_type : 2'd0;
                e_dir   = at;
                if (mis) begin
                    e_flush    = 1'b1;
                    e_redirect = at ? res_tar : res_pc + 32'd8;
                    mq.delete();
                end
                if (e_res_cnt != 32'hFFFF_FFFF) e_res_cnt = e_res_cnt + 32'd1;
                if (mis && e_mis_cnt != 32'hFFFF_FFFF) e_mis_cnt = e_mis_cnt + 32'd1;
            end
            if (do_push && !mis) begin
                n.pc = pred_pc; n.hit = pred_hit; n.dir = pred_dir; n.tar = pred_tar; n.typ = pred_type;
                mq.push_back(n);
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pred_valid = 1'b0; pred_pc = 32'd0; pred_hit = 1'b0; pred_dir = 1'b0;
        pred_tar = 32'd0; pred_type = 2'd0;
        res_valid = 1'b0; res_pc = 32'd0; res_is_branch = 1'b0; res_dir = 1'b0;
        res_tar = 32'd0; res_type = 2'd0;
    endtask

    task automatic set_pred(input logic [31:0] pc, input logic hit, input logic dir,
                            input logic [31:0] tar, input logic [1:0] typ);
        pred_valid = 1'b1; pred_pc = pc; pred_hit = hit; pred_dir = dir;
        pred_tar = tar; pred_type = typ;
    endtask

    task automatic set_res(input logic [31:0] pc, input logic br, input logic dir,
                           input logic [31:0] tar, input logic [1:0] typ);
        res_valid = 1'b1; res_pc = pc; res_is_branch = br; res_dir = dir;
        res_tar = tar; res_type = typ;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle_inputs();
        resetn = 1'b0;
        tick(); tick();
        resetn = 1'b1;
        checks++;
        if ({pred_ready, res_ready, upd_valid, flush, err_order} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 10000", {pred_ready, res_ready, upd_valid, flush, err_order});
        end
        checks++;
        if ({stat_resolved, stat_mispred, redirect_pc} !== 96'd0) begin
            errors++;
            $display("FAIL reset_stats: got %h %h %h expected 0", stat_resolved, stat_mispred, redirect_pc);
        end
    endtask

    task automatic test_correct_taken();
        set_pred(32'h1000, 1'b1, 1'b1, 32'h2000, 2'd1);
        tick();
        idle_inputs();
        set_res(32'h1000, 1'b1, 1'b1, 32'h2000, 2'd1);
        tick();
        idle_inputs();
        checks++;
        if ({upd_valid, upd_pred_flag, flush, upd_dir} !== 4'b1101) begin
            errors++;
            $display("FAIL correct_flags: got %b expected 1101", {upd_valid, upd_pred_flag, flush, upd_dir});
        end
        checks++;
        if (upd_tag !== 22'h4 || upd_index !== 8'h00) begin
            errors++;
            $display("FAIL correct_tagidx: got %h/%h expected 000004/00", upd_tag, upd_index);
        end
        tick();
        checks++;
        if (upd_valid !== 1'b0) begin
            errors++;
            $display("FAIL upd_one_cycle: got %b expected 0", upd_valid);
        end
    endtask

    task automatic test_miss_taken();
        set_pred(32'h1000, 1'b0, 1'b0, 32'h0, 2'd0);
        tick();
        idle_inputs();
        set_res(32'h1000, 1'b1, 1'b1, 32'h3000, 2'd1);
        tick();
        idle_inputs();
        checks++;
        if (flush !== 1'b1 || redirect_pc !== 32'h3000) begin
            errors++;
            $display("FAIL miss_flush: got %b/%h expected 1/00003000", flush, redirect_pc);
        end
        checks++;
        if (upd_pred_flag !== 1'b0 || upd_tar !== 32'h3000 || upd_valid !== 1'b1) begin
            errors++;
            $display("FAIL miss_upd: got %b/%h/%b expected 0/00003000/1", upd_pred_flag, upd_tar, upd_valid);
        end
        checks++;
        if (stat_mispred !== 32'd1 || stat_resolved !== 32'd2) begin
            errors++;
            $display("FAIL miss_stats: got %0d/%0d expected 1/2", stat_mispred, stat_resolved);
        end
    endtask

    task automatic test_false_hit();
        set_pred(32'h1000, 1'b1, 1'b1, 32'h2000, 2'd1);
        tick();
        idle_inputs();
        set_res(32'h1000, 1'b0, 1'b0, 32'h0, 2'd0);
        tick();
        idle_inputs();
        checks++;
        if (flush !== 1'b1 || redirect_pc !== 32'h1008) begin
            errors++;
            $display("FAIL falsehit_flush: got %b/%h expected 1/00001008", flush, redirect_pc);
        end
        checks++;
        if ({upd_valid, upd_pred_flag} !== 2'b10 || upd_tar !== 32'd0 || upd_type !== 2'd0) begin
            errors++;
            $display("FAIL falsehit_upd: got %b%b/%h/%h expected 10/0/0", upd_valid, upd_pred_flag, upd_tar, upd_type);
        end
    endtask

    task automatic test_full();
        logic [31:0] pc;
        for (int i = 0; i < 8; i++) begin
            set_pred(32'h8000 + 32'(i) * 32'd4, 1'b1, 1'b1, 32'h9000 + 32'(i) * 32'd16, 2'd1);
            tick();
        end
        idle_inputs();
        checks++;
        if ({pred_ready, res_ready} !== 2'b01) begin
            errors++;
            $display("FAIL full_ready: got %b expected 01", {pred_ready, res_ready});
        end
        // push while full with a simultaneous pop: push must be ignored
        set_pred(32'hDEAD0000, 1'b1, 1'b0, 32'h0, 2'd2);
        set_res(32'h8000, 1'b1, 1'b1, 32'h9000, 2'd1);
        tick();
        idle_inputs();
        checks++;
        if (pred_ready !== 1'b1 || flush !== 1'b0 || upd_pred_flag !== 1'b1) begin
            errors++;
            $display("FAIL full_pushpop: got %b/%b/%b expected 1/0/1", pred_ready, flush, upd_pred_flag);
        end
        for (int i = 1; i < 8; i++) begin
            pc = 32'h8000 + 32'(i) * 32'd4;
            set_res(pc, 1'b1, 1'b1, 32'h9000 + 32'(i) * 32'd16, 2'd1);
            tick();
            checks++;
            if (flush !== 1'b0 || upd_pred_flag !== 1'b1 || upd_index !== 8'((pc / 4) % 256)) begin
                errors++;
                $display("FAIL fifo_order[%0d]: got %b/%b/%h expected 0/1/%h", i, flush, upd_pred_flag, upd_index, 8'((pc / 4) % 256));
            end
        end
        idle_inputs();
        checks++;
        if (res_ready !== 1'b0 || err_order !== 1'b0) begin
            errors++;
            $display("FAIL drained: got %b/%b expected 0/0", res_ready, err_order);
        end
    endtask

    task automatic test_flush_order();
        set_pred(32'hA000, 1'b0, 1'b0, 32'h0, 2'd0);      tick();
        set_pred(32'hA004, 1'b1, 1'b0, 32'h0, 2'd1);      tick();
        set_pred(32'hA008, 1'b1, 1'b1, 32'hB000, 2'd1);   tick();
        set_pred(32'hA00C, 1'b1, 1'b1, 32'hB100, 2'd1);
        set_res(32'hA000, 1'b1, 1'b1, 32'hC000, 2'd2);
        tick();
        idle_inputs();
        checks++;
        if (flush !== 1'b1 || redirect_pc !== 32'hC000 || res_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_drop: got %b/%h/%b expected 1/0000c000/0", flush, redirect_pc, res_ready);
        end
        tick();
        checks++;
        if (res_ready !== 1'b0 || flush !== 1'b0) begin
            errors++;
            $display("FAIL flush_after: got %b/%b expected 0/0", res_ready, flush);
        end
        set_pred(32'hA010, 1'b1, 1'b1, 32'h6000, 2'd1);
        tick();
        idle_inputs();
        set_res(32'hA014, 1'b1, 1'b1, 32'h6000, 2'd1);
        tick();
        idle_inputs();
        checks++;
        if (err_order !== 1'b1 || flush !== 1'b1 || redirect_pc !== 32'h6000 || upd_pred_flag !== 1'b0) begin
            errors++;
            $display("FAIL order_err: got %b/%b/%h/%b expected 1/1/00006000/0", err_order, flush, redirect_pc, upd_pred_flag);
        end
        tick(); tick(); tick();
        checks++;
        if (err_order !== 1'b1) begin
            errors++;
            $display("FAIL order_sticky: got %b expected 1", err_order);
        end
    endtask

    task automatic test_random();
        logic [31:0] tars [4];
        tars[0] = 32'h2000; tars[1] = 32'h3000; tars[2] = 32'h4444; tars[3] = 32'h0;
        idle_inputs();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        for (int c = 0; c < 600; c++) begin
            resetn     = ($urandom_range(0, 59) != 0);
            pred_valid = ($urandom_range(0, 2) != 0);
            pred_pc    = $urandom & 32'hFFFF_FFFC;
            pred_hit   = 1'($urandom_range(0, 1));
            pred_dir   = 1'($urandom_range(0, 1));
            pred_tar   = tars[$urandom_range(0, 3)];
            pred_type  = 2'($urandom_range(0, 3));
            res_valid  = ($urandom_range(0, 2) == 0);
            res_is_branch = 1'($urandom_range(0, 1));
            res_dir    = 1'($urandom_range(0, 1));
            res_type   = 2'($urandom_range(0, 3));
            res_tar    = tars[$urandom_range(0, 3)];
            res_pc     = $urandom & 32'hFFFF_FFFC;
            if (mq.size() != 0) begin
                res_pc = mq[0].pc;
                if ($urandom_range(0, 24) == 0) res_pc = res_pc ^ 32'h4;
                if ($urandom_range(0, 1) == 1) res_tar = mq[0].tar;
                if ($urandom_range(0, 1) == 1) res_type = mq[0].typ;
            end
            tick();
            checks++;
            if (pred_ready !== (mq.size() != 8) || res_ready !== (mq.size() != 0)) begin
                errors++;
                $display("FAIL rnd_ready[%0d]: got %b%b expected %b%b", c, pred_ready, res_ready, mq.size() != 8, mq.size() != 0);
            end
            checks++;
            if (upd_valid !== e_upd_valid || flush !== e_flush || err_order !== e_err) begin
                errors++;
                $display("FAIL rnd_pulse[%0d]: got %b%b%b expected %b%b%b", c, upd_valid, flush, err_order, e_upd_valid, e_flush, e_err);
            end
            checks++;
            if (stat_resolved !== e_res_cnt || stat_mispred !== e_mis_cnt) begin
                errors++;
                $display("FAIL rnd_stats[%0d]: got %0d/%0d expected %0d/%0d", c, stat_resolved, stat_mispred, e_res_cnt, e_mis_cnt);
            end
            if (e_upd_valid) begin
                checks++;
                if ({upd_pred_flag, upd_tag, upd_index, upd_tar, upd_type, upd_dir} !==
                    {e_flag, e_tag, e_index, e_tar, e_type, e_dir}) begin
                    errors++;
                    $display("FAIL rnd_upd[%0d]: got %b %h %h %h %h %b expected %b %h %h %h %h %b", c,
                             upd_pred_flag, upd_tag, upd_index, upd_tar, upd_type, upd_dir,
                             e_flag, e_tag, e_index, e_tar, e_type, e_dir);
                end
            end
            if (e_flush) begin
                checks++;
                if (redirect_pc !== e_redirect) begin
                    errors++;
                    $display("FAIL rnd_redirect[%0d]: got %h expected %h", c, redirect_pc, e_redirect);
                end
            end
        end
        resetn = 1'b1;
        idle_inputs();
    endtask

    task automatic test_reset_cancel();
        idle_inputs();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        set_pred(32'h0100, 1'b0, 1'b0, 32'h0, 2'd0);
        tick();
        idle_inputs();
        set_res(32'h0100, 1'b1, 1'b1, 32'h0500, 2'd1);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        idle_inputs();
        checks++;
        if ({upd_valid, flush, res_ready, pred_ready} !== 4'b0001 || stat_resolved !== 32'd0 || stat_mispred !== 32'd0) begin
            errors++;
            $display("FAIL reset_cancel: got %b %0d %0d expected 0001 0 0", {upd_valid, flush, res_ready, pred_ready}, stat_resolved, stat_mispred);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        e_err = 1'b0; e_res_cnt = 32'd0; e_mis_cnt = 32'd0;
        resetn = 1'b0;
        idle_inputs();
        test_reset();
        test_correct_taken();
        test_miss_taken();
        test_false_hit();
        test_full();
        test_flush_order();
        test_random();
        test_reset_cancel();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
